// File: rtl/mca_histogram_if.sv
// Command, event, readout and status bundle for the MCA histogram engine.
// The histogram core connects through the slave modport; its driver connects through master.
interface mca_histogram_if #(
    parameter int unsigned CH_BITS = 10,
    parameter int unsigned CNT_W   = 32,
    parameter int unsigned DROP_W  = 16
);
    logic               cmd_start;
    logic               cmd_pause;
    logic               cmd_clear;
    logic               event_valid;
    logic [CH_BITS-1:0] event_channel;
    logic               event_ready;
    logic               rd_en;
    logic [CH_BITS-1:0] rd_addr;
    logic [CNT_W-1:0]   rd_data;
    logic               rd_valid;
    logic [1:0]         state;
    logic               busy;
    logic               overflow;
    logic [CNT_W-1:0]   total_count;
    logic [DROP_W-1:0]  dropped_count;

    modport master (
        output cmd_start, cmd_pause, cmd_clear,
        output event_valid, event_channel, rd_en, rd_addr,
        input  event_ready, rd_data, rd_valid,
        input  state, busy, overflow, total_count, dropped_count
    );

    modport slave (
        input  cmd_start, cmd_pause, cmd_clear,
        input  event_valid, event_channel, rd_en, rd_addr,
        output event_ready, rd_data, rd_valid,
        output state, busy, overflow, total_count, dropped_count
    );
endinterface

// File: rtl/mca_histogram.sv
// Multichannel-analyser histogram: per-channel saturating event counters in block RAM,
// with a 3-stage read-modify-write pipeline, a self-clearing sweep and random-access readout.
module mca_histogram #(
    parameter int unsigned CH_BITS = 10,
    parameter int unsigned CNT_W   = 32,
    parameter int unsigned DROP_W  = 16
) (
    input  logic           CLOCK_50,
    input  logic           rst,
    mca_histogram_if.slave bus
);
    localparam int unsigned N_CH = 2 ** CH_BITS;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_CLEAR = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0]   CNT_MAX  = '1;
    localparam logic [DROP_W-1:0]  DROP_MAX = '1;
    localparam logic [CH_BITS-1:0] LAST_CH  = '1;

    state_t             r_state;
    logic [CH_BITS-1:0] r_sweep;
    logic               r_busy;
    logic               r_overflow;
    logic [CNT_W-1:0]   r_total;
    logic [DROP_W-1:0]  r_dropped;

    logic               r_s1_valid;
    logic [CH_BITS-1:0] r_s1_ch;
    logic               r_s2_valid;
    logic [CH_BITS-1:0] r_s2_ch;
    logic [CNT_W-1:0]   r_s2_val;
    logic               r_rd_valid;
    logic               r_rd_fwd;

    logic [CNT_W-1:0]   r_ram [N_CH];
    logic [CNT_W-1:0]   r_ram_q;

    logic               w_accept;
    logic               w_clear_go;
    logic               w_s1_write;
    logic               w_s1_sat;
    logic [CNT_W-1:0]   w_s1_cur;
    logic [CNT_W-1:0]   w_s1_next;
    logic [CH_BITS-1:0] w_rd_ptr;
    logic               w_ram_we;
    logic [CH_BITS-1:0] w_wr_addr;
    logic [CNT_W-1:0]   w_wr_data;

    // Readout owns the single RAM read port whenever it asks for it.
    assign bus.event_ready = (r_state == ST_RUN) && !bus.rd_en;
    assign w_accept        = bus.event_valid && bus.event_ready;
    assign w_clear_go      = bus.cmd_clear && (r_state != ST_CLEAR);
    assign w_rd_ptr        = bus.rd_en ? bus.rd_addr : bus.event_channel;

    // The RAM read in S1 missed the write committed one edge earlier; take it from S2.
    assign w_s1_cur   = (r_s2_valid && (r_s2_ch == r_s1_ch)) ? r_s2_val : r_ram_q;
    assign w_s1_sat   = (w_s1_cur == CNT_MAX);
    assign w_s1_next  = w_s1_sat ? CNT_MAX : w_s1_cur + CNT_W'(1);
    assign w_s1_write = r_s1_valid && !w_clear_go;

    assign w_ram_we  = (r_state == ST_CLEAR) || w_s1_write;
    assign w_wr_addr = (r_state == ST_CLEAR) ? r_sweep : r_s1_ch;
    assign w_wr_data = (r_state == ST_CLEAR) ? '0 : w_s1_next;

    // Simple dual-port block RAM with registered read data, no reset.
    always_ff @(posedge CLOCK_50) begin
        if (w_ram_we) begin
            r_ram[w_wr_addr] <= w_wr_data;
        end
        r_ram_q <= r_ram[w_rd_ptr];
    end

    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_ch    <= '0;
            r_s2_valid <= 1'b0;
            r_s2_ch    <= '0;
            r_s2_val   <= '0;
            r_rd_valid <= 1'b0;
            r_rd_fwd   <= 1'b0;
        end else begin
            r_s1_valid <= w_accept && !w_clear_go;
            if (w_accept) begin
                r_s1_ch <= bus.event_channel;
            end
            r_s2_valid <= w_s1_write;
            if (w_s1_write) begin
                r_s2_ch  <= r_s1_ch;
                r_s2_val <= w_s1_next;
            end
            r_rd_valid <= bus.rd_en && (r_state != ST_CLEAR);
            r_rd_fwd   <= w_s1_write && (r_s1_ch == bus.rd_addr);
        end
    end

    // Control FSM plus status counters; the end of the sweep also wipes the statistics.
    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            r_state    <= ST_CLEAR;
            r_sweep    <= '0;
            r_busy     <= 1'b1;
            r_overflow <= 1'b0;
            r_total    <= '0;
            r_dropped  <= '0;
        end else begin
            if (w_accept && (r_total != CNT_MAX)) begin
                r_total <= r_total + CNT_W'(1);
            end
            if (bus.event_valid && ((r_state == ST_IDLE) || (r_state == ST_PAUSE))
                && (r_dropped != DROP_MAX)) begin
                r_dropped <= r_dropped + DROP_W'(1);
            end
            if (w_s1_write && w_s1_sat) begin
                r_overflow <= 1'b1;
            end

            case (r_state)
                ST_CLEAR: begin
                    r_sweep <= r_sweep + CH_BITS'(1);
                    if (r_sweep == LAST_CH) begin
                        r_state    <= ST_IDLE;
                        r_busy     <= 1'b0;
                        r_total    <= '0;
                        r_dropped  <= '0;
                        r_overflow <= 1'b0;
                    end
                end
                ST_IDLE: begin
                    if (bus.cmd_clear) begin
                        r_state <= ST_CLEAR;
                        r_busy  <= 1'b1;
                        r_sweep <= '0;
                    end else if (bus.cmd_start) begin
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (bus.cmd_clear) begin
                        r_state <= ST_CLEAR;
                        r_busy  <= 1'b1;
                        r_sweep <= '0;
                    end else if (bus.cmd_pause) begin
                        r_state <= ST_PAUSE;
                    end
                end
                default: begin
                    if (bus.cmd_clear) begin
                        r_state <= ST_CLEAR;
                        r_busy  <= 1'b1;
                        r_sweep <= '0;
                    end else if (bus.cmd_start) begin
                        r_state <= ST_RUN;
                    end
                end
            endcase
        end
    end

    // A read racing an S1 write to the same channel returns the value just written.
    assign bus.rd_data       = r_rd_valid ? (r_rd_fwd ? r_s2_val : r_ram_q) : '0;
    assign bus.rd_valid      = r_rd_valid;
    assign bus.state         = r_state;
    assign bus.busy          = r_busy;
    assign bus.overflow      = r_overflow;
    assign bus.total_count   = r_total;
    assign bus.dropped_count = r_dropped;
endmodule

// File: tb/tb_mca_histogram.sv
// Directed testbench for mca_histogram with 16 channels and 4-bit counters.
module tb_mca_histogram;
    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    mca_histogram_if #(.CH_BITS(4), .CNT_W(4), .DROP_W(8)) bus ();

    mca_histogram #(.CH_BITS(4), .CNT_W(4), .DROP_W(8)) dut (
        .CLOCK_50 (clk),
        .rst      (rst),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_read(input logic [3:0] a, output logic [3:0] d, output logic v);
        bus.rd_en   = 1'b1;
        bus.rd_addr = a;
        tick();
        d = bus.rd_data;
        v = bus.rd_valid;
        bus.rd_en = 1'b0;
    endtask

    task automatic send_event(input logic [3:0] ch);
        bus.event_valid   = 1'b1;
        bus.event_channel = ch;
        #1;
        n_vec++;
        if (bus.event_ready !== 1'b1) begin
            n_err++;
            $display("FAIL ev_ready ch%0d: got %b expected 1", ch, bus.event_ready);
        end
        tick();
        bus.event_valid = 1'b0;
    endtask

    task automatic test_reset();
        int n;
        logic [3:0] d;
        logic v;
        n_vec++;
        if (bus.state !== 2'b11 || bus.busy !== 1'b1 || bus.event_ready !== 1'b0 ||
            bus.rd_valid !== 1'b0 || bus.rd_data !== 4'd0 || bus.overflow !== 1'b0 ||
            bus.total_count !== 4'd0 || bus.dropped_count !== 8'd0) begin
            n_err++;
            $display("FAIL reset_vals: state=%b busy=%b rdy=%b rdv=%b rdd=%0d ovf=%b tot=%0d drp=%0d",
                     bus.state, bus.busy, bus.event_ready, bus.rd_valid, bus.rd_data,
                     bus.overflow, bus.total_count, bus.dropped_count);
        end
        tick();
        rst = 1'b0;
        n = 0;
        while (bus.busy === 1'b1 && n < 40) begin
            tick();
            n++;
        end
        n_vec++;
        if (n != 16) begin
            n_err++;
            $display("FAIL reset_sweep_len: got %0d cycles expected 16", n);
        end
        n_vec++;
        if (bus.state !== 2'b00) begin
            n_err++;
            $display("FAIL reset_idle: state=%b expected 00", bus.state);
        end
        for (int c = 0; c < 16; c++) begin
            do_read(4'(c), d, v);
            n_vec++;
            if (v !== 1'b1 || d !== 4'd0) begin
                n_err++;
                $display("FAIL reset_read ch%0d: valid=%b data=%0d expected 1/0", c, v, d);
            end
        end
        tick();
        n_vec++;
        if (bus.rd_valid !== 1'b0) begin
            n_err++;
            $display("FAIL rd_valid_pulse: got %b expected 0", bus.rd_valid);
        end
    endtask

    task automatic test_counting();
        logic [3:0] d;
        logic v;
        logic [3:0] seq [7];
        seq = '{4'd3, 4'd7, 4'd3, 4'd3, 4'd7, 4'd3, 4'd3};
        bus.cmd_start = 1'b1;
        tick();
        bus.cmd_start = 1'b0;
        n_vec++;
        if (bus.state !== 2'b01) begin
            n_err++;
            $display("FAIL start_run: state=%b expected 01", bus.state);
        end
        foreach (seq[i]) send_event(seq[i]);
        repeat (3) tick();
        do_read(4'd3, d, v);
        n_vec++;
        if (v !== 1'b1 || d !== 4'd5) begin
            n_err++;
            $display("FAIL count_ch3: valid=%b data=%0d expected 1/5", v, d);
        end
        do_read(4'd7, d, v);
        n_vec++;
        if (v !== 1'b1 || d !== 4'd2) begin
            n_err++;
            $display("FAIL count_ch7: valid=%b data=%0d expected 1/2", v, d);
        end
        n_vec++;
        if (bus.total_count !== 4'd7 || bus.overflow !== 1'b0) begin
            n_err++;
            $display("FAIL count_total: tot=%0d ovf=%b expected 7/0", bus.total_count, bus.overflow);
        end
        // read the channel whose update is being written on the same edge
        send_event(4'd5);
        do_read(4'd5, d, v);
        n_vec++;
        if (v !== 1'b1 || d !== 4'd1) begin
            n_err++;
            $display("FAIL read_forward_ch5: valid=%b data=%0d expected 1/1", v, d);
        end
        tick();
        n_vec++;
        if (bus.total_count !== 4'd8) begin
            n_err++;
            $display("FAIL total_after_ch5: got %0d expected 8", bus.total_count);
        end
    endtask

    task automatic test_saturation();
        logic [3:0] d;
        logic v;
        repeat (17) send_event(4'd1);
        repeat (3) tick();
        do_read(4'd1, d, v);
        n_vec++;
        if (v !== 1'b1 || d !== 4'd15) begin
            n_err++;
            $display("FAIL sat_ch1: valid=%b data=%0d expected 1/15", v, d);
        end
        n_vec++;
        if (bus.overflow !== 1'b1 || bus.total_count !== 4'd15) begin
            n_err++;
            $display("FAIL sat_flags: ovf=%b tot=%0d expected 1/15", bus.overflow, bus.total_count);
        end
        do_read(4'd3, d, v);
        n_vec++;
        if (d !== 4'd5) begin
            n_err++;
            $display("FAIL sat_ch3_intact: got %0d expected 5", d);
        end
    endtask

    task automatic test_pause();
        logic [3:0] d;
        logic v;
        send_event(4'd10);
        bus.event_valid   = 1'b1;
        bus.event_channel = 4'd10;
        bus.cmd_pause     = 1'b1;
        tick();
        bus.event_valid = 1'b0;
        bus.cmd_pause   = 1'b0;
        n_vec++;
        if (bus.state !== 2'b10) begin
            n_err++;
            $display("FAIL pause_state: state=%b expected 10", bus.state);
        end
        for (int i = 0; i < 3; i++) begin
            bus.event_valid   = 1'b1;
            bus.event_channel = 4'd9;
            #1;
            n_vec++;
            if (bus.event_ready !== 1'b0) begin
                n_err++;
                $display("FAIL pause_ready cyc%0d: got %b expected 0", i, bus.event_ready);
            end
            tick();
        end
        bus.event_valid = 1'b0;
        tick();
        n_vec++;
        if (bus.dropped_count !== 8'd3) begin
            n_err++;
            $display("FAIL pause_dropped: got %0d expected 3", bus.dropped_count);
        end
        do_read(4'd10, d, v);
        n_vec++;
        if (d !== 4'd2) begin
            n_err++;
            $display("FAIL pause_inflight_ch10: got %0d expected 2", d);
        end
        do_read(4'd9, d, v);
        n_vec++;
        if (d !== 4'd0) begin
            n_err++;
            $display("FAIL pause_ch9: got %0d expected 0", d);
        end
        bus.cmd_start = 1'b1;
        tick();
        bus.cmd_start = 1'b0;
        n_vec++;
        if (bus.state !== 2'b01) begin
            n_err++;
            $display("FAIL resume_state: state=%b expected 01", bus.state);
        end
        bus.cmd_start = 1'b1;
        bus.cmd_pause = 1'b1;
        tick();
        bus.cmd_start = 1'b0;
        bus.cmd_pause = 1'b0;
        n_vec++;
        if (bus.state !== 2'b10) begin
            n_err++;
            $display("FAIL pause_priority: state=%b expected 10", bus.state);
        end
        bus.cmd_start = 1'b1;
        tick();
        bus.cmd_start = 1'b0;
    endtask

    task automatic test_rd_stall();
        logic [3:0] d;
        logic v;
        bus.event_valid   = 1'b1;
        bus.event_channel = 4'd2;
        bus.rd_en         = 1'b1;
        bus.rd_addr       = 4'd0;
        for (int i = 0; i < 2; i++) begin
            #1;
            n_vec++;
            if (bus.event_ready !== 1'b0) begin
                n_err++;
                $display("FAIL stall_ready cyc%0d: got %b expected 0", i, bus.event_ready);
            end
            tick();
        end
        bus.rd_en = 1'b0;
        n_vec++;
        if (bus.rd_valid !== 1'b1 || bus.rd_data !== 4'd0) begin
            n_err++;
            $display("FAIL stall_read: valid=%b data=%0d expected 1/0", bus.rd_valid, bus.rd_data);
        end
        #1;
        n_vec++;
        if (bus.event_ready !== 1'b1) begin
            n_err++;
            $display("FAIL stall_release: got %b expected 1", bus.event_ready);
        end
        tick();
        bus.event_valid = 1'b0;
        repeat (3) tick();
        do_read(4'd2, d, v);
        n_vec++;
        if (d !== 4'd1 || bus.dropped_count !== 8'd3) begin
            n_err++;
            $display("FAIL stall_ch2: data=%0d drp=%0d expected 1/3", d, bus.dropped_count);
        end
    endtask

    task automatic test_clear();
        int n;
        logic [3:0] d;
        logic v;
        send_event(4'd4);
        bus.event_valid   = 1'b1;
        bus.event_channel = 4'd4;
        bus.cmd_clear     = 1'b1;
        tick();
        bus.event_valid = 1'b0;
        bus.cmd_clear   = 1'b0;
        n_vec++;
        if (bus.state !== 2'b11 || bus.busy !== 1'b1) begin
            n_err++;
            $display("FAIL clear_enter: state=%b busy=%b expected 11/1", bus.state, bus.busy);
        end
        bus.rd_en   = 1'b1;
        bus.rd_addr = 4'd1;
        tick();
        bus.rd_en = 1'b0;
        n = 1;
        n_vec++;
        if (bus.rd_valid !== 1'b0) begin
            n_err++;
            $display("FAIL clear_rd_ignored: rd_valid=%b expected 0", bus.rd_valid);
        end
        while (bus.busy === 1'b1 && n < 40) begin
            tick();
            n++;
        end
        n_vec++;
        if (n != 16) begin
            n_err++;
            $display("FAIL clear_sweep_len: got %0d cycles expected 16", n);
        end
        n_vec++;
        if (bus.state !== 2'b00 || bus.total_count !== 4'd0 ||
            bus.dropped_count !== 8'd0 || bus.overflow !== 1'b0) begin
            n_err++;
            $display("FAIL clear_stats: state=%b tot=%0d drp=%0d ovf=%b expected 00/0/0/0",
                     bus.state, bus.total_count, bus.dropped_count, bus.overflow);
        end
        for (int c = 0; c < 16; c++) begin
            do_read(4'(c), d, v);
            n_vec++;
            if (v !== 1'b1 || d !== 4'd0) begin
                n_err++;
                $display("FAIL clear_read ch%0d: valid=%b data=%0d expected 1/0", c, v, d);
            end
        end
    endtask

    task automatic test_reset_mid();
        int n;
        logic [3:0] d;
        logic v;
        bus.cmd_pause = 1'b1;
        tick();
        bus.cmd_pause = 1'b0;
        n_vec++;
        if (bus.state !== 2'b00) begin
            n_err++;
            $display("FAIL idle_pause_ignored: state=%b expected 00", bus.state);
        end
        bus.cmd_start = 1'b1;
        tick();
        bus.cmd_start = 1'b0;
        send_event(4'd6);
        repeat (3) tick();
        n_vec++;
        if (bus.total_count !== 4'd1) begin
            n_err++;
            $display("FAIL mid_total: got %0d expected 1", bus.total_count);
        end
        rst = 1'b1;
        #1;
        n_vec++;
        if (bus.state !== 2'b11 || bus.busy !== 1'b1 || bus.total_count !== 4'd0) begin
            n_err++;
            $display("FAIL mid_reset_async: state=%b busy=%b tot=%0d expected 11/1/0",
                     bus.state, bus.busy, bus.total_count);
        end
        tick();
        rst = 1'b0;
        n = 0;
        while (bus.busy === 1'b1 && n < 40) begin
            tick();
            n++;
        end
        n_vec++;
        if (n != 16 || bus.state !== 2'b00) begin
            n_err++;
            $display("FAIL mid_reset_sweep: cycles=%0d state=%b expected 16/00", n, bus.state);
        end
        do_read(4'd6, d, v);
        n_vec++;
        if (v !== 1'b1 || d !== 4'd0) begin
            n_err++;
            $display("FAIL mid_reset_ch6: valid=%b data=%0d expected 1/0", v, d);
        end
    endtask

    initial begin
        n_vec             = 0;
        n_err             = 0;
        rst               = 1'b1;
        bus.cmd_start     = 1'b0;
        bus.cmd_pause     = 1'b0;
        bus.cmd_clear     = 1'b0;
        bus.event_valid   = 1'b0;
        bus.event_channel = '0;
        bus.rd_en         = 1'b0;
        bus.rd_addr       = '0;
        #1;
        test_reset();
        test_counting();
        test_saturation();
        test_pause();
        test_rd_stall();
        test_clear();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/mca_histogram.md
Name: mca_histogram

Overview:
- Parametrised multichannel-analyser histogram engine. It accumulates per-channel event counts in on-chip block RAM.
- It is driven by the start/pause/clear command strobes that the USB command decoder produces.
- It serves random-access channel readout to the USB upload path and the hex display.
- Generalises the fixed 1024×32 scheme: adds configurable channel count and counter width, saturation with a sticky flag, dropped-event accounting, and a self-clearing sweep.

Parameters:
- CH_BITS, 10, log2 of channel count (channels = 2^CH_BITS).
- CNT_W, 32, width of each channel counter and of total_count.
- DROP_W, 16, width of the dropped-event counter.

Ports:
- CLOCK_50  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- cmd_start  in  1  single-cycle start/resume strobe.
- cmd_pause  in  1  single-cycle pause strobe.
- cmd_clear  in  1  single-cycle clear strobe.
- event_valid  in  1  event present on event_channel.
- event_channel  in  CH_BITS  channel index of the event.
- event_ready  out  1  event accepted this cycle when event_valid && event_ready.
- rd_en  in  1  readout request.
- rd_addr  in  CH_BITS  readout channel.
- rd_data  out  CNT_W  readout count.
- rd_valid  out  1  rd_data valid.
- state  out  2  00 IDLE, 01 RUN, 10 PAUSE, 11 CLEAR.
- busy  out  1  high in CLEAR.
- overflow  out  1  sticky: some channel saturated.
- total_count  out  CNT_W  accepted events, saturating.
- dropped_count  out  DROP_W  events presented while not accepting, saturating.

Behaviour:
- Reset values: state=CLEAR, sweep address=0, busy=1, event_ready=0, rd_valid=0, rd_data=0, overflow=0, total_count=0, dropped_count=0.
- Reset does not initialise RAM; the post-reset CLEAR sweep zeroes it.
- FSM transitions:
  - Command priority when strobes coincide: clear > pause > start.
  - IDLE: start→RUN; pause ignored.
  - RUN: pause→PAUSE; start ignored.
  - PAUSE: start→RUN.
  - Any of IDLE/RUN/PAUSE: clear→CLEAR.
  - CLEAR: all commands ignored. Sweep writes 0 to addresses 0..2^CH_BITS-1, one per cycle. After the last address the FSM goes to IDLE and clears total_count, dropped_count and overflow in the same cycle.
  - Sweep duration: exactly 2^CH_BITS cycles after entry.
- event_ready = (state==RUN) && !rd_en. Readout has priority for the shared RAM read port.
- Dropped events:
  - event_valid in IDLE or PAUSE: dropped_count increments (saturates at all-ones).
  - event_valid stalled by rd_en in RUN is not dropped; the source holds it.
  - Events in CLEAR are ignored and not counted.
- Update pipeline, 3 stages:
  - S0: accept event, latch channel.
  - S1: synchronous RAM read.
  - S2: compute count+1, saturating at 2^CNT_W-1, and write.
  - Sustained throughput: one event per cycle.
- Hazard forwarding: if the S1 channel equals the S2 channel, the S2 write value replaces the RAM read. Back-to-back and alternating same-channel events must yield exact counts.
- Saturation: a channel already at max stays at max and sets overflow (sticky until clear completes). total_count increments on every accept and saturates independently.
- Pause/clear with events in flight:
  - Pause mid-pipeline: in-flight events complete and are counted.
  - Clear mid-pipeline: in-flight S1/S2 writes are suppressed; the sweep starts the cycle after clear.
- Readout:
  - rd_en in IDLE/RUN/PAUSE: rd_data = RAM[rd_addr] with rd_valid=1 exactly 1 cycle later.
  - rd_valid is a single-cycle pulse per request.
  - Readout of a channel being updated in S2 returns the forwarded new value.
  - rd_en in CLEAR is ignored (rd_valid stays 0).
- Reset asserted mid-operation: immediate return to reset values and a restarted sweep.

Test Plan:
- CH_BITS=4. Release rst → busy=1 for exactly 16 cycles, then state=IDLE; reading ch0..15 returns 0 with rd_valid one cycle after each rd_en.
- cmd_start, then 5 consecutive events on ch3 plus 2 on ch7 interleaved (3,7,3,3,7,3,3) → ch3=5, ch7=2, total_count=7, overflow=0.
- CNT_W=4. 17 events on ch1 → ch1=15, overflow=1, total_count=15 (saturated).
- cmd_pause, 3 event_valid cycles → event_ready=0, dropped_count=3, no RAM change. cmd_start and cmd_pause in the same cycle from RUN → PAUSE.
- In RUN, hold rd_en for 2 cycles while event_valid on ch2 → event_ready=0 for those cycles; the event is accepted afterwards; ch2 increments exactly once.
- cmd_clear with 2 events in flight → both discarded; after 16 cycles all channels, total_count, dropped_count and overflow are 0; state=IDLE.
